// File: rtl/arb_client.sv
// Requester-side endpoint for the round-robin sticky-grant arbiter: buffers outbound
// words, requests while data is held, and yields for one cycle after MAX_BURST beats.
module arb_client #(
    parameter int DW        = 64,
    parameter int DEPTH     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    input  logic [DW-1:0]                in_data,
    output logic                         in_ready,
    output logic                         req,
    input  logic                         gnt,
    output logic                         out_valid,
    output logic [DW-1:0]                out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [1:0]                   dbg_state
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [BW-1:0] LAST_BEAT  = BW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        YIELD = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_next;
    logic [BW-1:0] beats, beats_next;
    logic          push, pop;

    // Full means full: a same-cycle pop never opens a slot for the incoming word.
    assign in_ready  = (count != FULL_COUNT);
    assign push      = in_valid & in_ready;
    assign req       = (state == REQ);
    assign out_valid = req & gnt & (count != '0);
    assign pop       = out_valid;
    assign out_data  = mem[rd_ptr];
    assign dbg_state = state;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (count != '0 || push) state_next = REQ;
            end
            REQ: begin
                // Burst limit wins over emptying so the yield cycle is never skipped.
                if (pop && beats == LAST_BEAT) begin
                    state_next = YIELD;
                end else if (pop && count == CW'(1) && !push) begin
                    state_next = IDLE;
                end
            end
            YIELD: begin
                state_next = (count_next != '0) ? REQ : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        beats_next = beats;
        if (state_next != REQ) begin
            beats_next = '0;
        end else if (pop) begin
            beats_next = beats + BW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            count  <= '0;
            beats  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            beats  <= beats_next;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule
